ula_arbitro: RTL
================

Name: ula_arbitro

Overview:
Shares a single instance of the team's 2-bit `ula` datapath (inputs A, B, S; outputs R, Cout) between two requesters. Each requester presents an operation with a valid/ready handshake. A round-robin arbiter grants one requester, latches its operands and drives the ALU from registers. The block returns a registered result tagged with the requester ID, and holds it until the consumer accepts it. It also keeps a per-requester completed-operation count for status/debug.

Parameters:
CNT_W, 8, width of each saturating completed-operation counter (>=2)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operation pending
req0_a  in  2  requester 0 operand A
req0_b  in  2  requester 0 operand B
req0_op  in  2  requester 0 opcode: 00 add, 01 sub, 10 and, 11 or
req0_ready  out  1  requester 0 operation accepted this cycle
req1_valid, req1_a, req1_b, req1_op, req1_ready  same as requester 0, for requester 1
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_id  out  1  requester that issued the result
resp_r  out  2  ALU result
resp_cout  out  1  ALU carry-out
busy  out  1  high whenever state != IDLE
cnt0  out  CNT_W  completed operations for requester 0 (saturating)
cnt1  out  CNT_W  completed operations for requester 1 (saturating)

Behaviour:
- ALU function, driven only from latched operands:
  - add: R=(A+B) mod 4, Cout=carry out of bit 1.
  - sub: R=(A+~B+1) mod 4, Cout=carry out (1 = no borrow).
  - and / or: bitwise, Cout=0.
- Reset:
  - Outputs: state=IDLE; all *_ready, resp_valid, resp_id, resp_r, resp_cout, busy = 0; cnt0 = cnt1 = 0.
  - Internal: last_id=1, so requester 0 wins the first contention. Operand registers = 0.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - Grant rules: only one valid -> that requester. Both valid -> requester != last_id. None valid -> no grant.
  - reqN_ready = (state==IDLE) & reqN_valid & grant==N. This is combinational; at most one ready is high per cycle.
  - On a clock edge with valid&ready: latch a, b, op and id; set last_id=id; go to EXEC.
- EXEC (exactly 1 cycle):
  - Register the ALU R/Cout into resp_r/resp_cout and id into resp_id.
  - Set resp_valid=1; go to RESP.
- RESP:
  - resp_valid=1; resp_id/r/cout held stable until resp_ready.
  - On an edge with resp_valid & resp_ready: resp_valid=0; increment cnt[resp_id], saturating at all-ones (no wrap); go to IDLE.
- Latency and throughput:
  - Accept at edge N -> resp_valid visible after edge N+1.
  - With resp_ready held high, the response completes at edge N+2. The next request can be accepted at edge N+3.
  - Peak rate is one operation per 3 cycles.
- Requester rules: a requester must hold valid, a, b and op stable until its ready is seen. Deasserting valid before acceptance withdraws the request with no side effects.
- No ready is asserted in EXEC or RESP. Requests arriving then wait; arbitration is evaluated fresh on return to IDLE.
- Reset asserted in any state aborts the in-flight operation: no response is produced and counters are cleared. Reset dominates a simultaneous handshake.
- busy = (state != IDLE), registered.

Test Plan:
- Req0 add a=3, b=1 with resp_ready=1 -> req0_ready high at accept edge; resp_valid after 1 edge with resp_id=0, resp_r=0, resp_cout=1; cnt0=1.
- Req1 sub a=1, b=2 -> resp_r=3, resp_cout=0. Then sub a=2, b=1 -> resp_r=1, resp_cout=1. Then and a=3, b=2 -> resp_r=2, resp_cout=0. Then or 1|2 -> resp_r=3, resp_cout=0. cnt1=4.
- Both valid continuously after reset -> grants alternate 0,1,0,1 with resp_id matching; never two readys in one cycle.
- resp_ready=0 for 5 cycles in RESP -> resp_valid/id/r/cout stable; both readys low; completion only on the edge where resp_ready=1.
- rst=1 during EXEC -> next cycle resp_valid=0, busy=0, cnt0=cnt1=0; first post-reset contention grants requester 0.
- CNT_W=2: 5 completed req0 ops -> cnt0 sequence 1,2,3,3,3 (saturates, no wrap).

Source files
------------

// File: rtl/ula_arbitro.sv
// ula_arbitro: two requesters share one 2-bit ALU through a round-robin
// arbiter and a three-state IDLE/EXEC/RESP sequencer.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid/a/b/op (N=0,1)     operation request (op: 00 add, 01 sub, 10 and, 11 or)
//   reqN_ready                    combinational accept strobe, only in IDLE
//   resp_valid/ready              registered result handshake
//   resp_id/r/cout                issuing requester, ALU result, carry-out
//   busy                          registered, high whenever not IDLE
//   cnt0/cnt1                     saturating completed-operation counters
module ula_arbitro #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [1:0]       req0_a,
  input  logic [1:0]       req0_b,
  input  logic [1:0]       req0_op,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_a,
  input  logic [1:0]       req1_b,
  input  logic [1:0]       req1_op,
  output logic             req1_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [1:0]       resp_r,
  output logic             resp_cout,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic       id;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] op;
  } op_t;

  state_t     state;
  logic       last_id;
  op_t        lat;
  op_t [1:0]  req;
  logic [1:0] vld;
  logic       gnt_id;
  logic       gnt_vld;
  logic [2:0] alu;   // {cout, r}

  assign req[0] = '{id: 1'b0, a: req0_a, b: req0_b, op: req0_op};
  assign req[1] = '{id: 1'b1, a: req1_a, b: req1_b, op: req1_op};
  assign vld    = {req1_valid, req0_valid};

  // Contention goes to whoever did not win last; otherwise the lone requester.
  always_comb begin
    gnt_id = vld[1];
    if (vld == 2'b11) gnt_id = ~last_id;
  end

  assign gnt_vld    = (state == IDLE) & (|vld);
  assign req0_ready = gnt_vld & ~gnt_id;
  assign req1_ready = gnt_vld &  gnt_id;

  // ALU runs only from the latched operands, never from the live request.
  always_comb begin
    alu = 3'd0;
    case (lat.op)
      2'b00: alu = {1'b0, lat.a} + {1'b0, lat.b};
      2'b01: alu = {1'b0, lat.a} + {1'b0, ~lat.b} + 3'd1;  // cout=1 means no borrow
      2'b10: alu = {1'b0, lat.a & lat.b};
      2'b11: alu = {1'b0, lat.a | lat.b};
      default: alu = 3'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_id    <= 1'b1;     // requester 0 wins the first contention
      lat        <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_r     <= 2'd0;
      resp_cout  <= 1'b0;
      busy       <= 1'b0;
      cnt0       <= '0;
      cnt1       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            lat     <= req[gnt_id];
            last_id <= gnt_id;
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          resp_r     <= alu[1:0];
          resp_cout  <= alu[2];
          resp_id    <= lat.id;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
            if (resp_id) begin
              if (cnt1 != '1) cnt1 <= cnt1 + CNT_W'(1);
            end else begin
              if (cnt0 != '1) cnt0 <= cnt0 + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
